bp_be_stride_prefetch_engine: RTL
=================================

// Module: bp_be_stride_prefetch_engine
// PURPOSE
//  Multi-entry reference-prediction table (RPT) plus prefetch burst generator.
//  Trains on committed load/store effective addresses keyed by PC.
//  Tracks per-PC signed stride with saturating confidence.
//  On a confirmed stride, issues up to degree_i prefetch addresses over a valid/ready port
//  toward the D$ prefetch queue.
// PARAMETERS
//  vaddr_width_p   39  virtual address / PC width
//  entries_p       16  RPT entries, fully associative, full-PC tag; power of 2
//  stride_width_p  12  signed stride width in bytes
//  conf_width_p    2   saturating confidence counter width
//  conf_thresh_p   2   confidence at or above which a burst triggers
//  degree_p        4   max prefetches per burst; degree_i is clamped to [1,degree_p]
//  train_stores_p  1   1: stores train the RPT; 0: stores ignored
// PORTS
//  clk_i            in   1               clock
//  reset_n_i        in   1               async active-low reset
//  flush_i          in   1               invalidate RPT, abort burst
//  degree_i         in   $clog2(degree_p)+1  runtime prefetch degree
//  train_v_i        in   1               training sample valid
//  train_pc_i       in   vaddr_width_p   PC of memory op
//  train_addr_i     in   vaddr_width_p   effective address
//  train_store_i    in   1               sample is a store
//  pf_v_o           out  1               prefetch address valid
//  pf_addr_o        out  vaddr_width_p   prefetch address
//  pf_ready_i       in   1               consumer accepts pf_addr_o
//  trig_drop_o      out  1               pulse: trigger lost, burst already active
// BEHAVIOUR
//  Reset (async, reset_n_i=0):
//   - All entries invalid; RR victim pointer = 0; FSM = IDLE.
//   - pf_v_o=0, pf_addr_o=0, trig_drop_o=0 immediately, independent of the clock.
//  Sample acceptance:
//   - Sample accepted iff train_v_i & ~flush_i & (~train_store_i | train_stores_p).
//   - Lookup is combinational; table updates at the next posedge.
//  Hit, with delta = train_addr_i - last_addr (mod 2^vaddr_width_p):
//   - delta fits signed stride_width_p, stride!=0 and delta==stride:
//     conf = sat_inc(conf); match = 1.
//   - else if conf>0: conf-1; stride unchanged.
//   - else: stride = delta if it fits, otherwise 0.
//   - last_addr = train_addr_i in all cases.
//  Miss:
//   - Allocate the lowest-index invalid entry, else the RR victim (pointer then +1, wraps).
//   - New entry: tag=pc, last_addr=addr, stride=0, conf=0.
//  Trigger: match & new conf >= conf_thresh_p.
//   - FSM IDLE: latch base=train_addr_i, stride, n=clamp(degree_i), k=1; go ISSUE.
//   - FSM ISSUE: trigger ignored; trig_drop_o=1 for one cycle.
//  ISSUE state:
//   - pf_v_o=1 with pf_addr_o = base + k*sext(stride), registered.
//   - First pf_v_o appears the cycle after the triggering sample's posedge (1-cycle latency).
//   - On pf_v_o & pf_ready_i: k+1. If k==n, return to IDLE and drop pf_v_o the next cycle.
//   - No bubbles between accepted addresses.
//   - pf_addr_o is held stable while pf_v_o & ~pf_ready_i; pf_v_o never retracts except on flush/reset.
//   - Address arithmetic wraps modulo 2^vaddr_width_p.
//  Flush:
//   - flush_i invalidates all entries, resets the RR pointer and forces IDLE.
//   - pf_v_o=0 from the next cycle.
//   - Flush wins over a same-cycle train or trigger.
//  Simultaneous events:
//   - A burst's final handshake coinciding with a new trigger: the trigger is dropped (FSM still ISSUE that cycle).
//   - RPT training continues during ISSUE.
// TESTING
//  1. thresh=2, degree_i=2; pc 0x100 trains 0x1000,0x1040,0x1080,0x10C0, ready=1 -> pf 0x1100,0x1140 back-to-back, then pf_v_o=0.
//  2. Same as 1 with pf_ready_i low 5 cycles at first pf_v_o -> pf_addr_o held 0x1100 throughout; no address skipped.
//  3. Negative stride, degree_i=3: 0x2000,0x1FF8,0x1FF0,0x1FE8 -> pf 0x1FE0,0x1FD8,0x1FD0.
//  4. Out-of-range delta 0x10000 (stride_width_p=12) x4 -> stride stays 0, no pf_v_o.
//     Then 17 distinct PCs -> entry 0 evicted; retraining PC0 is a miss.
//  5. flush_i mid-burst, and a trigger during ISSUE -> pf_v_o=0 next cycle and PC now misses;
//     trigger during ISSUE gives a one-cycle trig_drop_o pulse.
//  6. reset_n_i pulsed low between clock edges mid-burst -> pf_v_o=0 immediately; all PCs miss after release.

Source files
------------

// File: rtl/bp_be_stride_prefetch_engine.sv
// Stride reference-prediction table keyed by PC, plus a burst generator that
// issues strided prefetch addresses over a valid/ready port once a stride is confirmed.
module bp_be_stride_prefetch_engine #(
  parameter int vaddr_width_p  = 39,
  parameter int entries_p      = 16,
  parameter int stride_width_p = 12,
  parameter int conf_width_p   = 2,
  parameter int conf_thresh_p  = 2,
  parameter int degree_p       = 4,
  parameter bit train_stores_p = 1'b1,
  localparam int deg_w = $clog2(degree_p) + 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  input  logic [deg_w-1:0]         degree_i,
  input  logic                     train_v_i,
  input  logic [vaddr_width_p-1:0] train_pc_i,
  input  logic [vaddr_width_p-1:0] train_addr_i,
  input  logic                     train_store_i,
  output logic                     pf_v_o,
  output logic [vaddr_width_p-1:0] pf_addr_o,
  input  logic                     pf_ready_i,
  output logic                     trig_drop_o
);
  localparam int idx_w = $clog2(entries_p);
  localparam int aw    = vaddr_width_p;
  localparam int sw    = stride_width_p;
  localparam int cw    = conf_width_p;

  typedef enum logic {IDLE, ISSUE} state_e;

  logic [entries_p-1:0]  valid;
  logic [aw-1:0]         tag       [entries_p];
  logic [aw-1:0]         last_addr [entries_p];
  logic signed [sw-1:0]  stride    [entries_p];
  logic [cw-1:0]         conf      [entries_p];
  logic [idx_w-1:0]      rr;

  state_e               state;
  logic signed [sw-1:0] burst_stride;
  logic [deg_w-1:0]     n, k;
  logic                 pf_v, trig_drop;
  logic [aw-1:0]        pf_addr;

  function automatic logic [cw-1:0] sat_inc(input logic [cw-1:0] c);
    return (&c) ? c : c + cw'(1);
  endfunction

  function automatic logic [deg_w-1:0] clamp_degree(input logic [deg_w-1:0] d);
    if (d == '0) return deg_w'(1);
    if (d > deg_w'(degree_p)) return deg_w'(degree_p);
    return d;
  endfunction

  // A delta fits the stride field when its bits above the stride sign bit all copy it.
  function automatic logic fits_stride(input logic [aw-1:0] d);
    return (d[aw-1:sw-1] == '0) || (d[aw-1:sw-1] == '1);
  endfunction

  function automatic logic [aw-1:0] sext(input logic signed [sw-1:0] s);
    return {{(aw-sw){s[sw-1]}}, s};
  endfunction

  logic                 accept, hit, has_free, match, trigger, delta_fits;
  logic [idx_w-1:0]     hit_idx, free_idx, alloc_idx;
  logic [aw-1:0]        delta;
  logic [cw-1:0]        hit_conf_nxt;
  logic signed [sw-1:0] hit_stride_nxt;

  assign accept = train_v_i & ~flush_i & (~train_store_i | train_stores_p);

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = entries_p - 1; i >= 0; i--) begin
      if (valid[i] && (tag[i] == train_pc_i)) begin
        hit     = 1'b1;
        hit_idx = idx_w'(i);
      end
      if (!valid[i]) begin
        has_free = 1'b1;
        free_idx = idx_w'(i);
      end
    end
  end

  assign alloc_idx  = has_free ? free_idx : rr;
  assign delta      = train_addr_i - last_addr[hit_idx];
  assign delta_fits = fits_stride(delta);

  always_comb begin
    match          = 1'b0;
    hit_conf_nxt   = conf[hit_idx];
    hit_stride_nxt = stride[hit_idx];
    if (delta_fits && (stride[hit_idx] != '0) && ($signed(delta[sw-1:0]) == stride[hit_idx])) begin
      match        = 1'b1;
      hit_conf_nxt = sat_inc(conf[hit_idx]);
    end else if (conf[hit_idx] != '0) begin
      hit_conf_nxt = conf[hit_idx] - cw'(1);
    end else begin
      hit_stride_nxt = delta_fits ? $signed(delta[sw-1:0]) : '0;
    end
  end

  assign trigger = accept & hit & match & (hit_conf_nxt >= cw'(conf_thresh_p));

  // Table payload and burst parameters; qualified by valid/state, so never reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (hit) begin
        last_addr[hit_idx] <= train_addr_i;
        stride[hit_idx]    <= hit_stride_nxt;
        conf[hit_idx]      <= hit_conf_nxt;
      end else begin
        tag[alloc_idx]       <= train_pc_i;
        last_addr[alloc_idx] <= train_addr_i;
        stride[alloc_idx]    <= '0;
        conf[alloc_idx]      <= '0;
      end
    end
    if ((state == IDLE) && trigger) begin
      burst_stride <= hit_stride_nxt;
      n            <= clamp_degree(degree_i);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid     <= '0;
      rr        <= '0;
      state     <= IDLE;
      k         <= '0;
      pf_v      <= 1'b0;
      pf_addr   <= '0;
      trig_drop <= 1'b0;
    end else if (flush_i) begin
      valid     <= '0;
      rr        <= '0;
      state     <= IDLE;
      pf_v      <= 1'b0;
      trig_drop <= 1'b0;
    end else begin
      trig_drop <= trigger && (state == ISSUE);
      if (accept && !hit) begin
        valid[alloc_idx] <= 1'b1;
        if (!has_free) rr <= rr + idx_w'(1);
      end
      case (state)
        IDLE: begin
          if (trigger) begin
            state   <= ISSUE;
            pf_v    <= 1'b1;
            pf_addr <= train_addr_i + sext(hit_stride_nxt);
            k       <= deg_w'(1);
          end
        end
        ISSUE: begin
          if (pf_v && pf_ready_i) begin
            if (k == n) begin
              state <= IDLE;
              pf_v  <= 1'b0;
            end else begin
              k       <= k + deg_w'(1);
              pf_addr <= pf_addr + sext(burst_stride);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pf_v_o      = pf_v;
  assign pf_addr_o   = pf_addr;
  assign trig_drop_o = trig_drop;
endmodule
